// File: rtl/multicycle_control_fsm_if.sv
// ============================================================================
// Module   : multicycle_control_fsm_if
// Purpose  : Instruction/data memory request-ready handshake bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_fsm_if;
    logic instr_req;
    logic i_ready;
    logic data_req;
    logic data_we;
    logic d_ready;

    modport master (
        output instr_req,
        output data_req,
        output data_we,
        input  i_ready,
        input  d_ready
    );

    modport slave (
        input  instr_req,
        input  data_req,
        input  data_we,
        output i_ready,
        output d_ready
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Multi-cycle RV32I control unit with wait-state handshakes,
//            illegal-instruction and bus-timeout traps, retired counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    multicycle_control_fsm_if.master mem,
    input  wire logic [2:0]        fun3,
    input  wire logic [6:0]        fun7,
    input  wire logic              i_type,
    input  wire logic              r_type,
    input  wire logic              load,
    input  wire logic              store,
    input  wire logic              branch,
    input  wire logic              jal,
    input  wire logic              jalr,
    input  wire logic              lui,
    input  wire logic              auipc,
    input  wire logic              branch_taken,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_sel,
    output logic                   reg_write,
    output logic [1:0]             mem_to_reg,
    output logic                   operand_a,
    output logic                   operand_b,
    output logic [2:0]             imm_sel,
    output logic [3:0]             alu_control,
    output logic                   trap,
    output logic [1:0]             trap_cause,
    output logic [CNT_W-1:0]       instret
);

    localparam int TO_W = $clog2(TIMEOUT + 1) + 1;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TO_W-1:0]   wait_cnt;
    logic              timeout_hit;
    logic              illegal;
    logic              alt;
    logic [3:0]        dec_alu;
    logic [2:0]        dec_imm;
    logic [1:0]        dec_m2r;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_link;
    logic              retire;
    logic [1:0]        cause_next;
    logic              instr_req_c;
    logic              data_req_c;
    logic              data_we_c;

    assign alt         = (fun7 == 7'b0100000);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        illegal = !$onehot({i_type, r_type, load, store, branch, jal, jalr, lui, auipc});
        if (r_type && !((fun7 == 7'b0) || (alt && (fun3 == 3'b000 || fun3 == 3'b101))))
            illegal = 1'b1;
        if (i_type && fun3 == 3'b001 && fun7 != 7'b0)
            illegal = 1'b1;
        if (i_type && fun3 == 3'b101 && fun7 != 7'b0 && !alt)
            illegal = 1'b1;
        if (load && (fun3 == 3'b011 || fun3 == 3'b110 || fun3 == 3'b111))
            illegal = 1'b1;
        if (store && fun3 > 3'b010)
            illegal = 1'b1;
        if (branch && (fun3 == 3'b010 || fun3 == 3'b011))
            illegal = 1'b1;
        if (jalr && fun3 != 3'b000)
            illegal = 1'b1;
    end

    always_comb begin
        dec_alu = ALU_ADD;
        if (lui) begin
            dec_alu = ALU_PASS;
        end else if (r_type || i_type) begin
            case (fun3)
                3'b000:  dec_alu = (r_type && alt) ? ALU_SUB : ALU_ADD;
                3'b001:  dec_alu = ALU_SLL;
                3'b010:  dec_alu = ALU_SLT;
                3'b011:  dec_alu = ALU_SLTU;
                3'b100:  dec_alu = ALU_XOR;
                3'b101:  dec_alu = alt ? ALU_SRA : ALU_SRL;
                3'b110:  dec_alu = ALU_OR;
                default: dec_alu = ALU_AND;
            endcase
        end
        dec_imm = 3'b000;
        if (store)             dec_imm = 3'b001;
        else if (branch)       dec_imm = 3'b010;
        else if (jal)          dec_imm = 3'b011;
        else if (lui || auipc) dec_imm = 3'b100;
        dec_m2r = load ? 2'b01 : ((jal || jalr) ? 2'b10 : 2'b00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        instr_req_c = 1'b0;
        data_req_c  = 1'b0;
        data_we_c   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        reg_write   = 1'b0;
        retire      = 1'b0;
        cause_next  = 2'b00;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                instr_req_c = 1'b1;
                if (mem.i_ready) begin
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    cause_next = 2'b01;
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    cause_next = 2'b10;
                    state_next = S_TRAP;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else if (is_branch) begin
                    pc_write   = 1'b1;
                    pc_sel     = branch_taken;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                data_req_c = 1'b1;
                data_we_c  = is_store;
                if (mem.d_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    cause_next = 2'b01;
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_sel     = is_link;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_IDLE;
        endcase
    end

    assign mem.instr_req = instr_req_c;
    assign mem.data_req  = data_req_c;
    assign mem.data_we   = data_we_c;
    assign trap          = (state == S_TRAP);

    // Instruction class is latched at DECODE so later states ignore the live flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            imm_sel     <= 3'b000;
            operand_a   <= 1'b0;
            operand_b   <= 1'b0;
            mem_to_reg  <= 2'b00;
            alu_control <= 4'b0000;
            is_load     <= 1'b0;
            is_store    <= 1'b0;
            is_branch   <= 1'b0;
            is_link     <= 1'b0;
            trap_cause  <= 2'b00;
            instret     <= '0;
        end else begin
            if ((state == S_FETCH || state == S_MEM) && state_next == state)
                wait_cnt <= wait_cnt + TO_W'(1);
            else
                wait_cnt <= '0;
            if (state == S_DECODE) begin
                imm_sel     <= dec_imm;
                operand_a   <= branch || jal || auipc;
                operand_b   <= !r_type;
                mem_to_reg  <= dec_m2r;
                alu_control <= dec_alu;
                is_load     <= load;
                is_store    <= store;
                is_branch   <= branch;
                is_link     <= jal || jalr;
            end
            if (state != S_TRAP && state_next == S_TRAP)
                trap_cause <= cause_next;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
